// File: rtl/moore_pkg.sv
// Shared types for the Moore detector sequencer.
// Default pattern width is shared with the detector bench.
package moore_pkg;

  localparam int WIDTH_DEF = 20;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // Saturate a requested length to the pattern width.
  function automatic int unsigned clamp_len(
    input int unsigned l,
    input int unsigned w
  );
    return (l > w) ? w : l;
  endfunction

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in/serial-out register, MSB first,
// with a remaining-bit counter.
module seq_piso
  import moore_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  output logic             bit_out,
  output logic             last
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] aligned;
  logic [CNT_W-1:0] rem;

  // Put bit len-1 of the pattern at the MSB.
  always_comb begin
    aligned = pattern << (CNT_W'(WIDTH) - len);
  end

  // On load the first bit bypasses the register.
  assign bit_out = load ? aligned[WIDTH-1] : sr[WIDTH-1];
  assign last    = (rem == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr  <= '0;
      rem <= '0;
    end else if (load) begin
      sr  <= aligned << 1;
      rem <= len - CNT_W'(1);
    end else if (shift && !last) begin
      sr  <= sr << 1;
      rem <= rem - CNT_W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_scheduler.sv
// Drives a Moore detector serially from a pattern word and
// counts its y1/y2 responses two edges after each bit.
module moore_seq_scheduler
  import moore_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  output logic             x,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit1_cnt,
  output logic [CNT_W-1:0] hit2_cnt,
  output logic [WIDTH-1:0] y1_log
);

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0] len_c;
  logic             load;
  logic             shift;
  logic             bit_nxt;
  logic             last;
  logic             samp;

  always_comb begin
    len_c = CNT_W'(clamp_len(32'(len), WIDTH));
  end

  seq_piso #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .pattern (pattern),
    .len     (len_c),
    .bit_out (bit_nxt),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len_c == '0) begin
            state_n = DONE;
          end else begin
            load    = 1'b1;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (last) begin
          state_n = DRAIN;
        end else begin
          shift = 1'b1;
        end
      end
      // One cycle: the last bit's response is sampled here.
      DRAIN: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // samp marks edges whose y1/y2 answer a bit sent two edges earlier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x        <= 1'b0;
      samp     <= 1'b0;
      hit1_cnt <= '0;
      hit2_cnt <= '0;
      y1_log   <= '0;
    end else begin
      x    <= (load || shift) ? bit_nxt : 1'b0;
      samp <= (state == SHIFT);
      if (state == IDLE && start) begin
        hit1_cnt <= '0;
        hit2_cnt <= '0;
        y1_log   <= '0;
      end else if (samp) begin
        if (y1) hit1_cnt <= hit1_cnt + CNT_W'(1);
        if (y2) hit2_cnt <= hit2_cnt + CNT_W'(1);
        y1_log <= {y1_log[WIDTH-2:0], y1};
      end
    end
  end

endmodule
